// File: rtl/pipeline_perf_counter_if.sv
// pipeline_perf_counter_if: control, event and readback signals between the core-side bench and the counter bank.
interface pipeline_perf_counter_if #(parameter int CNT_W = 32, parameter int SEL_W = 3);
  logic start, stop, clear;
  logic wb_valid, stall, branch_taken;
  logic [1:0] forwardA, forwardB;
  logic [SEL_W-1:0] cnt_sel;
  logic [CNT_W-1:0] cnt_data;
  logic running;
  modport master (output start, stop, clear, wb_valid, stall, branch_taken, forwardA, forwardB, cnt_sel,
                  input cnt_data, running);
  modport slave (input start, stop, clear, wb_valid, stall, branch_taken, forwardA, forwardB, cnt_sel,
                 output cnt_data, running);
endinterface

// File: rtl/pipeline_perf_counter.sv
// pipeline_perf_counter: per-event hazard/retire counters with sticky wrap flags and a registered select readback.
module pipeline_perf_counter #(parameter int CNT_W = 32, parameter int SEL_W = 3) (
  input logic clk,
  input logic rstn,
  pipeline_perf_counter_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [CNT_W-1:0] cnt [7];
  logic [CNT_W-1:0] slot [8];
  logic [6:0] ovf, ev;
  always_comb begin
    state_next = (bus.start && !bus.stop) ? RUN : (bus.stop && !bus.start) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_next;
  end
  assign bus.running = (state == RUN);
  assign ev = {(|bus.forwardA) | (|bus.forwardB), |bus.forwardB, |bus.forwardA,
               bus.branch_taken, bus.stall, bus.wb_valid, 1'b1};
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
      ovf <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < 7; i++)
        if (ev[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
          if (&cnt[i]) ovf[i] <= 1'b1;
        end
    end
  end
  // slot 7 exposes the wrap flags; bit 7 is always zero
  always_comb begin
    for (int i = 0; i < 7; i++) slot[i] = cnt[i];
    slot[7] = CNT_W'({1'b0, ovf});
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bus.cnt_data <= '0;
    else bus.cnt_data <= slot[bus.cnt_sel];
  end
endmodule

// File: tb/tb_pipeline_perf_counter.sv
// tb_pipeline_perf_counter: directed test-plan scenarios plus random traffic checked against a cycle-level event model.
module tb_pipeline_perf_counter;
  localparam int W = 8;
  localparam int MOD = 1 << W;
  logic clk = 0, rstn = 0;
  int vectors = 0, errors = 0;
  int m_cnt [7];
  bit m_ovf [7];
  bit m_run;
  pipeline_perf_counter_if #(.CNT_W(W), .SEL_W(3)) bus ();
  pipeline_perf_counter #(.CNT_W(W), .SEL_W(3)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_val(input int s);
    int v = 0;
    if (s < 7) return m_cnt[s];
    for (int i = 0; i < 7; i++) if (m_ovf[i]) v += (1 << i);
    return v % MOD;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    m_run = 0;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    bus.wb_valid = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.forwardA = 0; bus.forwardB = 0;
  endtask

  // apply current inputs for one clock, advance model, compare readback and running
  task automatic step();
    bit e [7];
    int exp_data;
    exp_data = slot_val(int'(bus.cnt_sel));
    e[0] = 1; e[1] = bus.wb_valid; e[2] = bus.stall; e[3] = bus.branch_taken;
    e[4] = bus.forwardA != 0; e[5] = bus.forwardB != 0; e[6] = e[4] || e[5];
    if (bus.clear) for (int i = 0; i < 7; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    else if (m_run)
      for (int i = 0; i < 7; i++) if (e[i]) begin
        m_cnt[i] = (m_cnt[i] + 1) % MOD;
        if (m_cnt[i] == 0) m_ovf[i] = 1;
      end
    if (bus.start && !bus.stop) m_run = 1;
    else if (bus.stop && !bus.start) m_run = 0;
    @(posedge clk); #1;
    check("cnt_data", bus.cnt_data, exp_data);
    check("running", bus.running, m_run);
    idle_inputs();
  endtask

  task automatic rd(input int s, input int exp, input string tag);
    idle_inputs();
    bus.cnt_sel = 3'(s);
    step();
    check(tag, bus.cnt_data, exp);
  endtask

  initial begin
    idle_inputs();
    bus.cnt_sel = 0;
    model_reset();
    #12;
    check("reset_data", bus.cnt_data, 0);
    check("reset_running", bus.running, 0);
    rstn = 1;
    @(posedge clk); #1;
    // wb_valid held 10 cycles, last one is the stop cycle
    bus.start = 1; step();
    for (int i = 0; i < 10; i++) begin bus.wb_valid = 1; bus.stop = (i == 9); step(); end
    check("running_after_stop", bus.running, 0);
    rd(0, 10, "slot0_wb"); rd(1, 10, "slot1_wb");
    // clear with start: zero then RUN; stall/branch overlap by one cycle
    bus.clear = 1; bus.start = 1; step();
    bus.stall = 1; step();
    bus.stall = 1; step();
    bus.stall = 1; bus.branch_taken = 1; step();
    bus.branch_taken = 1; bus.stop = 1; step();
    rd(2, 3, "slot2_stall"); rd(3, 2, "slot3_branch"); rd(0, 4, "slot0_cycles");
    // forwarding overlap
    bus.clear = 1; bus.start = 1; step();
    for (int i = 0; i < 5; i++) begin
      bus.forwardA = (i < 4) ? 2'b10 : 2'b00;
      bus.forwardB = (i >= 2) ? 2'b01 : 2'b00;
      bus.stop = (i == 4);
      step();
    end
    rd(4, 4, "slot4_fwdA"); rd(5, 3, "slot5_fwdB"); rd(6, 5, "slot6_fwd_any");
    // simultaneous start/stop from IDLE is ignored
    bus.clear = 1; step();
    bus.start = 1; bus.stop = 1; step();
    check("start_stop_running", bus.running, 0);
    for (int i = 0; i < 5; i++) begin bus.wb_valid = 1; step(); end
    rd(0, 0, "start_stop_slot0");
    // wrap of slot1 after MOD+1 increments
    bus.start = 1; step();
    for (int i = 0; i < MOD + 1; i++) begin bus.wb_valid = 1; step(); end
    rd(1, 1, "wrap_slot1");
    bus.cnt_sel = 7; step();
    check("wrap_flag_bit1", bus.cnt_data[1], 1);
    bus.clear = 1; bus.cnt_sel = 1; step();
    rd(1, 0, "clear_slot1"); rd(7, 0, "clear_slot7");
    check("clear_keeps_run", bus.running, 1);
    // async reset mid-RUN
    for (int i = 0; i < 4; i++) begin bus.wb_valid = 1; bus.cnt_sel = 0; step(); end
    #2 rstn = 0; #1;
    model_reset();
    check("async_rst_data", bus.cnt_data, 0);
    check("async_rst_running", bus.running, 0);
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin bus.wb_valid = 1; bus.stall = 1; step(); end
    rd(1, 0, "post_rst_slot1"); rd(0, 0, "post_rst_slot0");
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.start = ($urandom_range(0, 19) == 0);
      bus.stop = ($urandom_range(0, 29) == 0);
      bus.clear = ($urandom_range(0, 199) == 0);
      bus.wb_valid = $urandom_range(0, 1);
      bus.stall = $urandom_range(0, 1);
      bus.branch_taken = $urandom_range(0, 1);
      bus.forwardA = 2'($urandom_range(0, 3));
      bus.forwardB = 2'($urandom_range(0, 3));
      bus.cnt_sel = 3'($urandom_range(0, 7));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_perf_counter.md
Name: pipeline_perf_counter

Overview:
Hardware event counter bank that sits directly downstream of the pipelined CPU core, alongside the simulation bench. It consumes the core's hazard and retire status signals (stall, branch taken, forwardA/forwardB, MEM/WB valid) and accumulates per-event counts. The counts are read back through a select/data port in the same style as the register-file debug port. This replaces per-cycle $display scraping with synthesizable statistics.

Parameters:
CNT_W, 32, width of each event counter and of cnt_data
SEL_W, 3, width of cnt_sel; 8 readable slots

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begin counting
stop  input  1  single-cycle pulse; stop counting, hold values
clear  input  1  single-cycle pulse; zero all counters and overflow flags
wb_valid  input  1  instruction retiring in MEM/WB this cycle
stall  input  1  load-use stall asserted this cycle
branch_taken  input  1  branch/jump redirect this cycle
forwardA  input  2  ALU operand A forward select; 2'b00 = none
forwardB  input  2  ALU operand B forward select; 2'b00 = none
cnt_sel  input  SEL_W  readback slot select
cnt_data  output  CNT_W  registered readback value
running  output  1  high while FSM is in RUN

Behaviour:
- Reset (rstn low, async): all counters 0, overflow flags 0, FSM IDLE, running 0, cnt_data 0.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - start and stop asserted in the same cycle: ignored, state unchanged.
- running is a registered output equal to (state == RUN).
- Counting: a counter increments on a rising edge only if the state was RUN during that cycle and its event was true.
  - Events in the start cycle are not counted.
  - Events in the stop cycle are counted.
- Slots:
  - 0: cycles in RUN
  - 1: wb_valid
  - 2: stall
  - 3: branch_taken
  - 4: forwardA != 0
  - 5: forwardB != 0
  - 6: cycles with (forwardA != 0 || forwardB != 0), counted once per cycle
  - 7: overflow flag vector, zero-extended to CNT_W; bit i is the sticky wrap flag of slot i (i = 0..6); bit 7 reads 0
- Simultaneous events are counted independently (e.g. stall and wb_valid in the same cycle both increment).
- Clear has priority over increments and over start/stop.
  - Counters and flags are 0 after the clear edge.
  - Events in the clear cycle are not counted.
  - FSM state is unaffected by clear (clear in RUN keeps counting from 0 the next cycle).
  - clear together with start: zero, then enter RUN.
- Wrap-around: an increment at 2^CNT_W-1 yields 0 and sets that slot's overflow flag. The flag remains set until clear or reset. Counting continues after wrap.
- Readback: cnt_data <= slot[cnt_sel] every cycle; latency is 1 cycle.
  - cnt_data reflects counter values as of the previous edge (pre-increment of the current cycle).
  - Readback is valid in both IDLE and RUN.
- Inputs are sampled synchronously only. No X-propagation handling is required beyond reset.
- Reset mid-RUN: immediate return to IDLE with all state cleared; counting resumes only after a new start.

Test Plan:
- Reset then start; hold wb_valid=1 for 10 cycles; stop; cnt_sel=0 then 1 -> both read 10 one cycle after select; running falls the cycle after stop.
- In RUN, drive stall=1 for 3 cycles and branch_taken=1 for 2 cycles, overlapping by 1 cycle -> slot2=3, slot3=2; slot0 equals total RUN cycles.
- Forwarding: forwardA=2'b10 for 4 cycles, forwardB=2'b01 for 3 cycles, 2 cycles overlapping -> slot4=4, slot5=3, slot6=5.
- Start and stop in the same cycle from IDLE -> running stays 0; slot0 stays 0 after 5 cycles.
- CNT_W=4: 17 wb_valid cycles in RUN -> slot1=1, slot7 bit1=1; then clear -> slot1=0, slot7=0, running still 1.
- Assert rstn low mid-RUN with nonzero counts -> cnt_data=0 and running=0 immediately; events after release are not counted until start.
